// File: rtl/id_ex_stage_reg_pkg.sv
// Shared encodings for the ID/EX pipeline register: ALU opcodes, field widths
// and the control values that make up a pipeline bubble.
package id_ex_stage_reg_pkg;

    localparam int ALU_OP_W    = 5;
    localparam int MEM_WRITE_W = 3;
    localparam int MEM_READ_W  = 4;
    localparam int BRANCH_W    = 4;
    localparam int WB_SEL_W    = 2;

    typedef enum logic [ALU_OP_W-1:0] {
        OP_ADD  = 5'b00000,
        OP_SUB  = 5'b00001,
        OP_SLL  = 5'b00010,
        OP_SLT  = 5'b00011,
        OP_SLTU = 5'b00100,
        OP_XOR  = 5'b00101,
        OP_SRL  = 5'b00110,
        OP_SRA  = 5'b00111,
        OP_OR   = 5'b01000,
        OP_AND  = 5'b01001,
        OP_LUI  = 5'b01010,
        OP_AUIPC = 5'b01011
    } alu_op_e;

    // Control values carried by a bubble: nothing stored, loaded or branched.
    localparam logic [MEM_WRITE_W-1:0] MEM_WRITE_NONE = 3'b000;
    localparam logic [MEM_READ_W-1:0]  MEM_READ_NONE  = 4'b0000;
    localparam logic [BRANCH_W-1:0]    BRANCH_NONE    = 4'b0000;

    function automatic logic is_load(input logic [MEM_READ_W-1:0] mem_read);
        return mem_read[MEM_READ_W-1];
    endfunction

endpackage

// File: rtl/id_ex_stage_reg_sat_counter.sv
// Saturating up-counter: clears on reset, sticks at all-ones instead of wrapping.
module sat_counter #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             inc,
    output logic [CNT_W-1:0] count
);

    localparam logic [CNT_W-1:0] ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    always_ff @(posedge clk) begin
        if (!reset) begin
            count <= '0;
        end else if (inc && (count != '1)) begin
            count <= count + ONE;
        end
    end

endmodule

// File: rtl/id_ex_stage_reg.sv
// ID/EX pipeline register with load-use bubble insertion, branch squash,
// downstream hold and saturating stall/flush event counters.
module id_ex_stage_reg
    import id_ex_stage_reg_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int REG_AW = 5,
    parameter int CNT_W  = 16
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [DATA_W-1:0]      id_pc,
    input  logic [DATA_W-1:0]      id_data1,
    input  logic [DATA_W-1:0]      id_data2,
    input  logic [DATA_W-1:0]      id_imm,
    input  logic [REG_AW-1:0]      id_rs1,
    input  logic [REG_AW-1:0]      id_rs2,
    input  logic [REG_AW-1:0]      id_rd,
    input  logic                   id_rs1_used,
    input  logic                   id_rs2_used,
    input  logic [ALU_OP_W-1:0]    id_alu_op,
    input  logic                   id_reg_write_en,
    input  logic [MEM_WRITE_W-1:0] id_mem_write,
    input  logic [MEM_READ_W-1:0]  id_mem_read,
    input  logic [BRANCH_W-1:0]    id_branch_jump,
    input  logic                   id_data1_alu_sel,
    input  logic                   id_data2_alu_sel,
    input  logic [WB_SEL_W-1:0]    id_wb_sel,
    input  logic                   branch_taken,
    input  logic                   hold_in,
    output logic [DATA_W-1:0]      ex_pc,
    output logic [DATA_W-1:0]      ex_data1,
    output logic [DATA_W-1:0]      ex_data2,
    output logic [DATA_W-1:0]      ex_imm,
    output logic [REG_AW-1:0]      ex_rs1,
    output logic [REG_AW-1:0]      ex_rs2,
    output logic [REG_AW-1:0]      ex_rd,
    output logic [ALU_OP_W-1:0]    ex_alu_op,
    output logic                   ex_reg_write_en,
    output logic [MEM_WRITE_W-1:0] ex_mem_write,
    output logic [MEM_READ_W-1:0]  ex_mem_read,
    output logic [BRANCH_W-1:0]    ex_branch_jump,
    output logic                   ex_data1_alu_sel,
    output logic                   ex_data2_alu_sel,
    output logic [WB_SEL_W-1:0]    ex_wb_sel,
    output logic                   ex_valid,
    output logic                   stall_out,
    output logic [CNT_W-1:0]       stall_count,
    output logic [CNT_W-1:0]       flush_count
);

    logic lu_hazard;
    logic load_bubble;
    logic flush_inc;

    // A load into x0 never produces a value worth waiting for.
    always_comb begin
        lu_hazard = ex_valid && is_load(ex_mem_read) && (ex_rd != '0) &&
                    (((ex_rd == id_rs1) && id_rs1_used) ||
                     ((ex_rd == id_rs2) && id_rs2_used));
    end

    assign stall_out   = reset & (hold_in | (lu_hazard & ~branch_taken));
    assign load_bubble = branch_taken | lu_hazard;
    assign flush_inc   = reset & branch_taken & ~hold_in;

    always_ff @(posedge clk) begin
        if (!reset || (!hold_in && load_bubble)) begin
            ex_pc            <= '0;
            ex_data1         <= '0;
            ex_data2         <= '0;
            ex_imm           <= '0;
            ex_rs1           <= '0;
            ex_rs2           <= '0;
            ex_rd            <= '0;
            ex_alu_op        <= '0;
            ex_reg_write_en  <= 1'b0;
            ex_mem_write     <= MEM_WRITE_NONE;
            ex_mem_read      <= MEM_READ_NONE;
            ex_branch_jump   <= BRANCH_NONE;
            ex_data1_alu_sel <= 1'b0;
            ex_data2_alu_sel <= 1'b0;
            ex_wb_sel        <= '0;
            ex_valid         <= 1'b0;
        end else if (!hold_in) begin
            ex_pc            <= id_pc;
            ex_data1         <= id_data1;
            ex_data2         <= id_data2;
            ex_imm           <= id_imm;
            ex_rs1           <= id_rs1;
            ex_rs2           <= id_rs2;
            ex_rd            <= id_rd;
            ex_alu_op        <= id_alu_op;
            ex_reg_write_en  <= id_reg_write_en;
            ex_mem_write     <= id_mem_write;
            ex_mem_read      <= id_mem_read;
            ex_branch_jump   <= id_branch_jump;
            ex_data1_alu_sel <= id_data1_alu_sel;
            ex_data2_alu_sel <= id_data2_alu_sel;
            ex_wb_sel        <= id_wb_sel;
            ex_valid         <= 1'b1;
        end
    end

    sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
        .clk   (clk),
        .reset (reset),
        .inc   (stall_out),
        .count (stall_count)
    );

    sat_counter #(.CNT_W(CNT_W)) u_flush_cnt (
        .clk   (clk),
        .reset (reset),
        .inc   (flush_inc),
        .count (flush_count)
    );

endmodule
